// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: one shared period counter feeding NCH compare channels.
// Edge- or center-aligned counting, per-channel polarity, and double-buffered
// configuration that moves from shadow to active only at period boundaries
// (or at once while disabled).
module pwm_multi_gen #(
    parameter int CBITS = 12,
    parameter int NCH   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_load,
    input  logic [CBITS-1:0]     cfg_period,
    input  logic [NCH*CBITS-1:0] cfg_duty,
    input  logic                 cfg_center,
    input  logic [NCH-1:0]       cfg_invert,
    output logic [NCH-1:0]       pwm_out,
    output logic                 cycle_start,
    output logic                 cfg_pending
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [CBITS-1:0] CNT_ONE = CBITS'(1);

    // Counter state
    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] cnt_next;
    dir_t             dir;
    dir_t             dir_next;

    // Active configuration (what the counter and comparators use now)
    logic [CBITS-1:0]     act_period;
    logic [NCH*CBITS-1:0] act_duty;
    logic                 act_center;
    logic [NCH-1:0]       act_invert;

    // Shadow configuration (waiting for the next boundary)
    logic [CBITS-1:0]     sh_period;
    logic [NCH*CBITS-1:0] sh_duty;
    logic                 sh_center;
    logic [NCH-1:0]       sh_invert;

    logic           boundary;
    logic           transfer;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] pwm_next;

    // Detect the last cycle of the current period; P==0 makes every cycle one.
    // In center mode with P==1 the period is just 0,1 so the peak is also the end.
    always_comb begin
        boundary = 1'b0;
        if (act_period == '0) begin
            boundary = 1'b1;
        end else if (!act_center) begin
            boundary = (cnt == act_period);
        end else begin
            boundary = (cnt == CNT_ONE) && ((dir == DIR_DOWN) || (act_period == CNT_ONE));
        end
    end

    // Shadow moves to active at a boundary, or on any disabled cycle
    assign transfer = cfg_pending && (!en || boundary);

    // Next counter value and direction; boundary and disable both restart from 0 counting up
    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        if (!en || boundary) begin
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (!act_center) begin
            cnt_next = cnt + CNT_ONE;
        end else if (dir == DIR_UP) begin
            if (cnt == act_period) begin
                cnt_next = cnt - CNT_ONE;
                dir_next = DIR_DOWN;
            end else begin
                cnt_next = cnt + CNT_ONE;
            end
        end else begin
            cnt_next = cnt - CNT_ONE;
        end
    end

    // Per-channel compare and polarity; disabled channels sit at their inactive level
    always_comb begin
        raw = '0;
        for (int i = 0; i < NCH; i++) begin
            raw[i] = (cnt < act_duty[i*CBITS +: CBITS]);
        end
        pwm_next = en ? (raw ^ act_invert) : act_invert;
    end

    // Counter and direction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else begin
            cnt <= cnt_next;
            dir <= dir_next;
        end
    end

    // Shadow capture, shadow-to-active transfer and pending flag.
    // A load on a transfer cycle still sees the old shadow being copied out.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_period   <= '0;
            sh_duty     <= '0;
            sh_center   <= 1'b0;
            sh_invert   <= '0;
            act_period  <= '1;
            act_duty    <= '0;
            act_center  <= 1'b0;
            act_invert  <= '0;
            cfg_pending <= 1'b0;
        end else begin
            if (transfer) begin
                act_period <= sh_period;
                act_duty   <= sh_duty;
                act_center <= sh_center;
                act_invert <= sh_invert;
            end
            if (cfg_load) begin
                sh_period <= cfg_period;
                sh_duty   <= cfg_duty;
                sh_center <= cfg_center;
                sh_invert <= cfg_invert;
            end
            if (cfg_load) begin
                cfg_pending <= 1'b1;
            end else if (transfer) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    // Registered outputs, one cycle behind the counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out     <= '0;
            cycle_start <= 1'b0;
        end else begin
            pwm_out     <= pwm_next;
            cycle_start <= en && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: directed and random stimulus with a phase-based reference
// model; expected outputs are queued and checked by an independent monitor.
module tb_pwm_multi_gen;

    localparam int CBITS = 8;
    localparam int NCH   = 3;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic                 cfg_load;
    logic [CBITS-1:0]     cfg_period;
    logic [NCH*CBITS-1:0] cfg_duty;
    logic                 cfg_center;
    logic [NCH-1:0]       cfg_invert;
    logic [NCH-1:0]       pwm_out;
    logic                 cycle_start;
    logic                 cfg_pending;

    pwm_multi_gen #(.CBITS(CBITS), .NCH(NCH)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_center  (cfg_center),
        .cfg_invert  (cfg_invert),
        .pwm_out     (pwm_out),
        .cycle_start (cycle_start),
        .cfg_pending (cfg_pending)
    );

    typedef struct {
        logic [NCH-1:0] pwm;
        logic           cs;
        logic           pend;
        int             cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_item;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_num  = 0;

    // Reference model: position inside the period plus active/shadow configuration
    int       m_k;
    int       m_p;
    int       m_d[NCH];
    bit       m_center;
    bit [2:0] m_inv;
    int       s_p;
    int       s_d[NCH];
    bit       s_center;
    bit [2:0] s_inv;
    bit       m_pend;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int period_len();
        if (m_p == 0) return 1;
        return m_center ? 2 * m_p : m_p + 1;
    endfunction

    function automatic int cnt_of(input int k);
        if (!m_center || k <= m_p) return k;
        return 2 * m_p - k;
    endfunction

    task automatic modelReset();
        m_k      = 0;
        m_p      = (1 << CBITS) - 1;
        m_center = 1'b0;
        m_inv    = '0;
        s_p      = 0;
        s_center = 1'b0;
        s_inv    = '0;
        m_pend   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_d[i] = 0;
            s_d[i] = 0;
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic applyStimulus(input bit r, input bit e, input bit ld, input int p,
                                 input int d0, input int d1, input int d2,
                                 input bit c, input bit [2:0] inv);
        exp_t x;
        int   cnt;
        int   len;
        bit   last;
        bit   xfer;
        int   dv[NCH];
        @(negedge clk);
        dv[0] = d0 & 255;
        dv[1] = d1 & 255;
        dv[2] = d2 & 255;
        rst        = r;
        en         = e;
        cfg_load   = ld;
        cfg_period = 8'(p);
        cfg_duty   = {8'(dv[2]), 8'(dv[1]), 8'(dv[0])};
        cfg_center = c;
        cfg_invert = inv;
        x.cyc = cyc_num;
        cyc_num++;
        if (r) begin
            modelReset();
            x.pwm  = '0;
            x.cs   = 1'b0;
            x.pend = 1'b0;
        end else begin
            cnt  = cnt_of(m_k);
            len  = period_len();
            last = (m_k == len - 1);
            for (int i = 0; i < NCH; i++) begin
                x.pwm[i] = e ? ((cnt < m_d[i]) ^ m_inv[i]) : m_inv[i];
            end
            x.cs = e && (cnt == 0);
            xfer = m_pend && (!e || last);
            m_k  = (!e || last) ? 0 : m_k + 1;
            if (xfer) begin
                m_p      = s_p;
                m_center = s_center;
                m_inv    = s_inv;
                for (int i = 0; i < NCH; i++) m_d[i] = s_d[i];
            end
            if (ld) begin
                s_p      = p & 255;
                s_center = c;
                s_inv    = inv;
                for (int i = 0; i < NCH; i++) s_d[i] = dv[i];
                m_pend = 1'b1;
            end else if (xfer) begin
                m_pend = 1'b0;
            end
            x.pend = m_pend;
        end
        sb_q.push_back(x);
    endtask

    // Compare one DUT output sample against the queued expectation
    task automatic checkOutput(input exp_t x);
        n_checks++;
        if (pwm_out === x.pwm) n_pass++;
        else $display("[TB] FAIL pwm_out cycle %0d: got %b expected %b", x.cyc, pwm_out, x.pwm);
        n_checks++;
        if (cycle_start === x.cs) n_pass++;
        else $display("[TB] FAIL cycle_start cycle %0d: got %b expected %b", x.cyc, cycle_start, x.cs);
        n_checks++;
        if (cfg_pending === x.pend) n_pass++;
        else $display("[TB] FAIL cfg_pending cycle %0d: got %b expected %b", x.cyc, cfg_pending, x.pend);
    endtask

    // Monitor: pop and compare once per clock, shortly after the active edge
    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            mon_item = sb_q.pop_front();
            checkOutput(mon_item);
        end
    end

    // Enabled cycles with no load and junk on the cfg inputs
    task automatic holdRun(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 1, 0, $urandom, $urandom, $urandom, $urandom, $urandom, 3'($urandom));
        end
    endtask

    task automatic holdOff(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom, 3'($urandom));
        end
    endtask

    // Run enabled until the model says the next cycle sits at period phase target
    task automatic runToPhase(input int target);
        int guard;
        guard = 0;
        while (m_k != target && guard < 1000) begin
            holdRun(1);
            guard++;
        end
        if (m_k != target) begin
            n_checks++;
            $display("[TB] FAIL runToPhase timeout: phase %0d wanted %0d", m_k, target);
        end
    endtask

    // Top-level sequence: directed scenarios, then a random soak
    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        cfg_load   = 1'b0;
        cfg_period = '0;
        cfg_duty   = '0;
        cfg_center = 1'b0;
        cfg_invert = '0;
        modelReset();

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 3'b000);

        $display("[TB] edge mode P=9 D={10,5,0}");
        applyStimulus(0, 0, 1, 9, 0, 5, 10, 0, 3'b000);
        holdOff(1);
        holdRun(32);

        $display("[TB] shadow load mid-period and on boundary");
        runToPhase(3);
        applyStimulus(0, 1, 1, 9, 0, 7, 10, 0, 3'b000);
        holdRun(24);
        runToPhase(9);
        applyStimulus(0, 1, 1, 9, 0, 3, 10, 0, 3'b000);
        holdRun(26);

        $display("[TB] center mode P=4 D[1]=2");
        applyStimulus(0, 1, 1, 4, 0, 2, 0, 1, 3'b000);
        runToPhase(0);
        holdRun(26);

        $display("[TB] center mode P=1 and P=2");
        applyStimulus(0, 0, 1, 1, 1, 2, 0, 1, 3'b010);
        holdOff(1);
        holdRun(8);
        applyStimulus(0, 0, 1, 2, 1, 2, 3, 1, 3'b000);
        holdOff(1);
        holdRun(10);

        $display("[TB] disable and polarity");
        applyStimulus(0, 0, 1, 9, 0, 5, 10, 0, 3'b101);
        holdOff(3);
        applyStimulus(0, 0, 1, 3, 1, 2, 4, 0, 3'b101);
        holdOff(2);
        holdRun(12);

        $display("[TB] degenerate P=0");
        applyStimulus(0, 0, 1, 0, 0, 1, 200, 0, 3'b000);
        holdOff(1);
        holdRun(6);
        applyStimulus(0, 1, 1, 0, 1, 0, 5, 1, 3'b000);
        holdRun(6);

        $display("[TB] reset mid-run");
        applyStimulus(0, 0, 1, 9, 0, 5, 10, 0, 3'b000);
        holdOff(1);
        runToPhase(5);
        applyStimulus(1, 1, 0, 9, 0, 5, 10, 0, 3'b000);
        applyStimulus(1, 1, 0, 9, 0, 5, 10, 0, 3'b000);
        holdRun(10);

        $display("[TB] random soak");
        for (int n = 0; n < 1500; n++) begin
            bit r;
            bit e;
            bit ld;
            int p;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 19) == 0);
            p  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 12));
            applyStimulus(r, e, ld, p, $urandom_range(0, 14), $urandom_range(0, 14),
                          $urandom_range(0, 255), $urandom_range(0, 1), 3'($urandom));
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("[TB] FAIL scoreboard drain: %0d left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
